// File: rtl/sa_tile_ctrl_pkg.sv
// Shared types and constants for the systolic-array tile sequencer.
// Holds the phase enum, the array geometry constants and the phase-length helper.
// The top module imports this package to size its counter and set its terminal counts.
package sa_tile_ctrl_pkg;

    localparam int ARRAYWIDTH          = 4;
    localparam int DATASIZE            = 16;
    localparam int OUTPUT_BUF_DATASIZE = 2 * DATASIZE + 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_LOAD,
        ST_W_SHIFT,
        ST_A_LOAD,
        ST_STREAM,
        ST_WAIT,
        ST_DRAIN,
        ST_O_OUT,
        ST_DONE
    } state_e;

    // Number of counted cycles (or accepted rows) spent in a phase.
    // A skewed N x N array needs 3N-2 cycles before the last partial sum leaves it.
    function automatic int phase_len(input state_e st, input int n, input int pipe_lat);
        case (st)
            ST_W_LOAD, ST_W_SHIFT, ST_A_LOAD,
            ST_DRAIN, ST_O_OUT: phase_len = n;
            ST_STREAM:          phase_len = 3 * n - 2;
            ST_WAIT:            phase_len = pipe_lat;
            default:            phase_len = 1;
        endcase
    endfunction

endpackage

// File: rtl/sa_tile_ctrl.sv
// Tile sequencer: steps the systolic-array buffer enables through load, shift, stream, drain, readout.
// Latency: start -> done is 1 + 4N + (3N-2) + PIPE_LAT + N cycles when the host never stalls.
// Backpressure: row_ready is high only in the two load phases; a missing row_valid just holds the phase.
module sa_tile_ctrl #(
    parameter int ARRAYWIDTH = sa_tile_ctrl_pkg::ARRAYWIDTH,
    parameter int PIPE_LAT   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    input  logic row_valid,
    output logic row_ready,
    output logic weight_buffer_load_en,
    output logic weight_buffer_out_en,
    output logic write_weight_en,
    output logic input_buffer_load_en,
    output logic input_buffer_out_en,
    output logic output_buffer_load_en,
    output logic output_buffer_out_en,
    output logic res_valid
);
    import sa_tile_ctrl_pkg::*;

    localparam int CNT_W = $clog2(3 * ARRAYWIDTH + PIPE_LAT) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    // Terminal values: the phase ends on the cycle the counter sits at length-1.
    localparam cnt_t ROW_LAST    = cnt_t'(phase_len(ST_W_LOAD, ARRAYWIDTH, PIPE_LAT) - 1);
    localparam cnt_t STREAM_LAST = cnt_t'(phase_len(ST_STREAM, ARRAYWIDTH, PIPE_LAT) - 1);
    localparam cnt_t WAIT_LAST   = cnt_t'(phase_len(ST_WAIT, ARRAYWIDTH, PIPE_LAT) - 1);

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   res_valid_q;
    logic   step;

    // State, phase counter and the delayed readout flag; reset drops straight back to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_valid_q <= output_buffer_out_en;
        end
    end

    // Next phase and counter; the counter restarts from zero whenever the phase changes.
    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_W_LOAD;
            end
            ST_W_LOAD: begin
                step = row_valid;
                if (row_valid && cnt_q == ROW_LAST) state_d = ST_W_SHIFT;
            end
            ST_W_SHIFT: begin
                step = 1'b1;
                if (cnt_q == ROW_LAST) state_d = ST_A_LOAD;
            end
            ST_A_LOAD: begin
                step = row_valid;
                if (row_valid && cnt_q == ROW_LAST) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                step = 1'b1;
                if (cnt_q == STREAM_LAST) state_d = (PIPE_LAT == 0) ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                step = 1'b1;
                if (cnt_q == WAIT_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                step = 1'b1;
                if (cnt_q == ROW_LAST) state_d = ST_O_OUT;
            end
            ST_O_OUT: begin
                step = 1'b1;
                if (cnt_q == ROW_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + cnt_t'(step);
    end

    // Enable decode from the registered phase; only the two load enables also look at row_valid.
    always_comb begin
        busy                  = (state_q != ST_IDLE);
        done                  = 1'b0;
        row_ready             = 1'b0;
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
        input_buffer_load_en  = 1'b0;
        input_buffer_out_en   = 1'b0;
        output_buffer_load_en = 1'b0;
        output_buffer_out_en  = 1'b0;
        res_valid             = res_valid_q;
        case (state_q)
            ST_W_LOAD: begin
                row_ready             = 1'b1;
                weight_buffer_load_en = row_valid;
            end
            ST_W_SHIFT: begin
                weight_buffer_out_en = 1'b1;
                write_weight_en      = 1'b1;
            end
            ST_A_LOAD: begin
                row_ready            = 1'b1;
                input_buffer_load_en = row_valid;
            end
            ST_STREAM: input_buffer_out_en   = 1'b1;
            ST_DRAIN:  output_buffer_load_en = 1'b1;
            ST_O_OUT:  output_buffer_out_en  = 1'b1;
            ST_DONE:   done                  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Bench for sa_tile_ctrl: two instances (N=4/PIPE_LAT=2 and N=1/PIPE_LAT=0).
// A phase-schedule model predicts every output on every cycle; directed tiles
// add hand-computed timing expectations (done cycle, pulse counts, first cycles).
module tb_sa_tile_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start_r, rv_r;
    logic [1:0] busy_w, done_w, rdy_w, wbl_w, wbo_w, wwe_w, ibl_w, ibo_w, obl_w, obo_w, resv_w;

    sa_tile_ctrl #(.ARRAYWIDTH(4), .PIPE_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start_r[0]), .busy(busy_w[0]), .done(done_w[0]),
        .row_valid(rv_r[0]), .row_ready(rdy_w[0]),
        .weight_buffer_load_en(wbl_w[0]), .weight_buffer_out_en(wbo_w[0]),
        .write_weight_en(wwe_w[0]), .input_buffer_load_en(ibl_w[0]),
        .input_buffer_out_en(ibo_w[0]), .output_buffer_load_en(obl_w[0]),
        .output_buffer_out_en(obo_w[0]), .res_valid(resv_w[0])
    );

    sa_tile_ctrl #(.ARRAYWIDTH(1), .PIPE_LAT(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .busy(busy_w[1]), .done(done_w[1]),
        .row_valid(rv_r[1]), .row_ready(rdy_w[1]),
        .weight_buffer_load_en(wbl_w[1]), .weight_buffer_out_en(wbo_w[1]),
        .write_weight_en(wwe_w[1]), .input_buffer_load_en(ibl_w[1]),
        .input_buffer_out_en(ibo_w[1]), .output_buffer_load_en(obl_w[1]),
        .output_buffer_out_en(obo_w[1]), .res_valid(resv_w[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Output bundle order: busy done row_ready wbl wbo wwe ibl ibo obl obo res_valid
    function automatic logic [10:0] outv(input int i);
        return {busy_w[i], done_w[i], rdy_w[i], wbl_w[i], wbo_w[i], wwe_w[i],
                ibl_w[i], ibo_w[i], obl_w[i], obo_w[i], resv_w[i]};
    endfunction

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 weight rows, 2 weight shift, 3 act rows, 4 stream,
    // 5 wait, 6 drain, 7 readout, 8 done. m_left = rows/cycles still owed.
    int n_cfg [2] = '{4, 1};
    int p_cfg [2] = '{2, 0};
    int m_ph [2]   = '{0, 0};
    int m_left [2] = '{0, 0};
    bit m_prev [2] = '{1'b0, 1'b0};

    function automatic int plen(input int i, input int ph);
        case (ph)
            4:       return 3 * n_cfg[i] - 2;
            5:       return p_cfg[i];
            8:       return 1;
            default: return n_cfg[i];
        endcase
    endfunction

    function automatic int next_ph(input int i, input int ph);
        if (ph == 4 && p_cfg[i] == 0) return 6;
        return ph + 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_ph[i] = 0; m_left[i] = 0; m_prev[i] = 1'b0;
            end else begin
                m_prev[i] = (m_ph[i] == 7);
                if (m_ph[i] == 0) begin
                    if (start_r[i]) begin m_ph[i] = 1; m_left[i] = n_cfg[i]; end
                end else if (m_ph[i] == 8) begin
                    m_ph[i] = 0;
                end else if ((m_ph[i] != 1 && m_ph[i] != 3) || rv_r[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_ph[i]   = next_ph(i, m_ph[i]);
                        m_left[i] = plen(i, m_ph[i]);
                    end
                end
            end
        end
    end

    function automatic logic [10:0] expv(input int i);
        int   ph;
        logic r;
        ph = m_ph[i];
        r  = rv_r[i];
        if (!rst) return '0;
        return {ph != 0, ph == 8, (ph == 1 || ph == 3), (ph == 1) && r, ph == 2, ph == 2,
                (ph == 3) && r, ph == 4, ph == 6, ph == 7, m_prev[i]};
    endfunction

    // Every cycle, mid-period: both instances against the model.
    always @(negedge clk) begin
        chkv("cycle_outputs_u0", outv(0), expv(0));
        chkv("cycle_outputs_u1", outv(1), expv(1));
    end

    // ---------------- directed tile runner ----------------
    // Cycle c is the c-th cycle after the edge that samples start (edge 0).
    task automatic run(input int inst, input int ncyc, input int stall_a, input int stall_b,
                       input int rst_at, input bit extra_starts,
                       output int d1, output int d2, output int dcnt,
                       output int rfirst, output int rcnt, output int wbl, output int ibl,
                       output int ibo1, output int obl1);
        d1 = -1; d2 = -1; dcnt = 0; rfirst = -1; rcnt = 0; wbl = 0; ibl = 0; ibo1 = -1; obl1 = -1;
        @(posedge clk); #1;
        start_r[inst] = 1'b1;
        rv_r[inst]    = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= ncyc; c++) begin
            start_r[inst] = extra_starts && (c == 5 || c == 20 || c == 33 || c == 34);
            rv_r[inst]    = !(c >= stall_a && c <= stall_b);
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                chkv("async_reset_zero", outv(inst), '0);
            end
            if (c == rst_at + 2) rst = 1'b1;
            #1;
            if (done_w[inst]) begin
                if (dcnt == 0) d1 = c; else if (dcnt == 1) d2 = c;
                dcnt++;
            end
            if (resv_w[inst]) begin
                if (rcnt == 0) rfirst = c;
                rcnt++;
            end
            if (wbl_w[inst]) wbl++;
            if (ibl_w[inst]) ibl++;
            if (ibo_w[inst] && ibo1 < 0) ibo1 = c;
            if (obl_w[inst] && obl1 < 0) obl1 = c;
            @(posedge clk); #1;
        end
        start_r[inst] = 1'b0;
        rv_r[inst]    = 1'b0;
    endtask

    int d1, d2, dcnt, rf, rc, wb, ib, ibo1, obl1;

    initial begin
        rst = 1'b0; start_r = '0; rv_r = '0;
        repeat (3) @(posedge clk);
        #1;
        chkv("reset_state_u0", outv(0), '0);
        chkv("reset_state_u1", outv(1), '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Tile with no stalls, row_valid held high through every phase.
        run(0, 40, 0, -1, 0, 1'b0, d1, d2, dcnt, rf, rc, wb, ib, ibo1, obl1);
        chk("s1_done_cycle", d1, 33);
        chk("s1_done_count", dcnt, 1);
        chk("s1_res_first", rf, 30);
        chk("s1_res_count", rc, 4);
        chk("s1_wload_pulses", wb, 4);
        chk("s1_aload_pulses", ib, 4);
        chk("s1_stream_first", ibo1, 13);
        chk("s1_drain_first", obl1, 25);

        // Host stalls for 3 cycles inside the weight-row phase.
        run(0, 45, 2, 4, 0, 1'b0, d1, d2, dcnt, rf, rc, wb, ib, ibo1, obl1);
        chk("s2_done_cycle", d1, 36);
        chk("s2_wload_pulses", wb, 4);
        chk("s2_res_first", rf, 33);

        // start while busy / in DONE ignored; start right after DONE begins the next tile.
        run(0, 72, 0, -1, 0, 1'b1, d1, d2, dcnt, rf, rc, wb, ib, ibo1, obl1);
        chk("s3_first_done", d1, 33);
        chk("s3_second_done", d2, 67);
        chk("s3_done_count", dcnt, 2);

        // Reset mid-stream, then a clean tile must match the first one exactly.
        run(0, 25, 0, -1, 15, 1'b0, d1, d2, dcnt, rf, rc, wb, ib, ibo1, obl1);
        chk("s4_no_done_after_reset", dcnt, 0);
        chk("s4_busy_after_reset", busy_w[0], 0);
        run(0, 40, 0, -1, 0, 1'b0, d1, d2, dcnt, rf, rc, wb, ib, ibo1, obl1);
        chk("s4_retile_done", d1, 33);
        chk("s4_retile_res_first", rf, 30);

        // N=1, PIPE_LAT=0: every phase one cycle, readout coincides with done.
        run(1, 12, 0, -1, 0, 1'b0, d1, d2, dcnt, rf, rc, wb, ib, ibo1, obl1);
        chk("n1_done_cycle", d1, 7);
        chk("n1_done_count", dcnt, 1);
        chk("n1_res_first", rf, 7);
        chk("n1_res_count", rc, 1);
        chk("n1_stream_first", ibo1, 4);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
